// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C target.
// Optional general-call matching is enabled by defining I2C_TARGET_GENCALL_EN.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_tgt_state_t;

   localparam logic [6:0] GENCALL_ADDR = 7'h00;

   // ab = received address byte {addr[6:0], rw}
   function automatic logic addr_match(input logic [7:0] ab, input logic [6:0] own);
      logic m;
      m = (ab[7:1] == own);
`ifdef I2C_TARGET_GENCALL_EN
      // General call is write-only; a general-call read is never acknowledged.
      if ((ab[7:1] == GENCALL_ADDR) && !ab[0]) m = 1'b1;
`endif
      return m;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus edge and START/STOP detection.
// Event outputs are combinational from registered signals, one clock after the sync chain.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   w_scl_s;
   logic                   w_sda_s;

   // Reset to the idle-bus level so leaving reset never looks like an event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_d    <= w_scl_s;
         r_sda_d    <= w_sda_s;
      end
   end

   assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];

   assign scl_rise  =  w_scl_s & ~r_scl_d;
   assign scl_fall  = ~w_scl_s &  r_scl_d;
   assign start_det =  w_scl_s &  r_scl_d &  r_sda_d & ~w_sda_s;
   assign stop_det  =  w_scl_s &  r_scl_d & ~r_sda_d &  w_sda_s;
   assign sda_s     =  w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write receive into rx_data, read serve from tx_data.
// Define I2C_TARGET_GENCALL_EN to also accept general-call (7'h00 + W) writes.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_o,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       busy,
   output logic       rw_dir
);

   logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda_i     (sda_i),
      .scl_rise  (w_scl_rise),
      .scl_fall  (w_scl_fall),
      .start_det (w_start),
      .stop_det  (w_stop),
      .sda_s     (w_sda_s)
   );

   i2c_tgt_state_t r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_sh, w_sh_nxt;
   logic [7:0] r_rx_data, w_rx_data_nxt;
   logic       r_sda_o, w_sda_nxt;
   logic       r_rx_valid, w_rx_valid_nxt;
   logic       r_tx_load, w_tx_load_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_rw, w_rw_nxt;
   logic       r_mack, w_mack_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_sh       <= 8'h00;
         r_rx_data  <= 8'h00;
         r_sda_o    <= 1'b1;
         r_rx_valid <= 1'b0;
         r_tx_load  <= 1'b0;
         r_busy     <= 1'b0;
         r_rw       <= 1'b0;
         r_mack     <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sh       <= w_sh_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_sda_o    <= w_sda_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_tx_load  <= w_tx_load_nxt;
         r_busy     <= w_busy_nxt;
         r_rw       <= w_rw_nxt;
         r_mack     <= w_mack_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_sh_nxt       = r_sh;
      w_rx_data_nxt  = r_rx_data;
      w_sda_nxt      = r_sda_o;
      w_rx_valid_nxt = 1'b0;
      w_tx_load_nxt  = 1'b0;
      w_busy_nxt     = r_busy;
      w_rw_nxt       = r_rw;
      w_mack_nxt     = r_mack;

      if (w_stop) begin
         w_state_nxt = IDLE;
         w_sda_nxt   = 1'b1;
         w_busy_nxt  = 1'b0;
         w_cnt_nxt   = 4'd0;
      end else if (w_start) begin
         w_state_nxt = ADDR;
         w_sda_nxt   = 1'b1;
         w_busy_nxt  = 1'b0;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            IDLE: w_sda_nxt = 1'b1;

            ADDR: begin
               if (w_scl_rise) begin
                  w_sh_nxt  = {r_sh[6:0], w_sda_s};
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                  w_cnt_nxt = 4'd0;
                  if (addr_match(r_sh, TARGET_ADDR)) begin
                     w_state_nxt = ADDR_ACK;
                     w_sda_nxt   = 1'b0;
                     w_busy_nxt  = 1'b1;
                     w_rw_nxt    = r_sh[0];
                  end else begin
                     w_state_nxt = IGNORE;
                  end
               end
            end

            ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nxt = 4'd0;
                  if (r_rw) begin
                     w_tx_load_nxt = 1'b1;
                     w_sh_nxt      = tx_data;
                     w_sda_nxt     = tx_data[7];
                     w_state_nxt   = RD_DATA;
                  end else begin
                     w_sda_nxt     = 1'b1;
                     w_state_nxt   = WR_DATA;
                  end
               end
            end

            WR_DATA: begin
               if (w_scl_rise) begin
                  w_sh_nxt  = {r_sh[6:0], w_sda_s};
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                  w_cnt_nxt = 4'd0;
                  if (rx_ready) begin
                     w_rx_data_nxt  = r_sh;
                     w_rx_valid_nxt = 1'b1;
                     w_sda_nxt      = 1'b0;
                     w_state_nxt    = WR_ACK;
                  end else begin
                     w_sda_nxt      = 1'b1;
                     w_busy_nxt     = 1'b0;
                     w_state_nxt    = IGNORE;
                  end
               end
            end

            WR_ACK: begin
               if (w_scl_fall) begin
                  w_sda_nxt   = 1'b1;
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = WR_DATA;
               end
            end

            // Bit 7 went out on entry, so falls 1..7 present bits 6..0 and fall 8 releases.
            RD_DATA: begin
               if (w_scl_fall) begin
                  if (r_cnt == 4'd7) begin
                     w_sda_nxt   = 1'b1;
                     w_cnt_nxt   = 4'd0;
                     w_state_nxt = RD_ACK;
                  end else begin
                     w_sh_nxt    = {r_sh[6:0], 1'b0};
                     w_sda_nxt   = r_sh[6];
                     w_cnt_nxt   = r_cnt + 4'd1;
                  end
               end
            end

            RD_ACK: begin
               if (w_scl_rise) begin
                  w_mack_nxt = w_sda_s;
               end else if (w_scl_fall) begin
                  w_cnt_nxt = 4'd0;
                  if (!r_mack) begin
                     w_tx_load_nxt = 1'b1;
                     w_sh_nxt      = tx_data;
                     w_sda_nxt     = tx_data[7];
                     w_state_nxt   = RD_DATA;
                  end else begin
                     w_sda_nxt     = 1'b1;
                     w_busy_nxt    = 1'b0;
                     w_state_nxt   = IGNORE;
                  end
               end
            end

            IGNORE: begin
               w_sda_nxt  = 1'b1;
               w_busy_nxt = 1'b0;
            end

            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign sda_o    = r_sda_o;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_load  = r_tx_load;
   assign busy     = r_busy;
   assign rw_dir   = r_rw;

endmodule
